// File: rtl/mshr_wake_ctrl.sv
// Miss-status holding registers for one M-stage cache bank: merges misses per line, issues one
// bus request per line and replays each waiter as a one-cycle wake pulse after the fill returns.
module mshr_wake_ctrl #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned LINE_AW     = 28,
    parameter int unsigned PTCID_W     = 7,
    parameter int unsigned QSLOTS      = 8,
    localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES),
    localparam int unsigned OCC_W      = IDX_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic [LINE_AW-1:0] alloc_line_addr,
    input  logic [PTCID_W-1:0] alloc_ptcid,
    input  logic [QSLOTS-1:0]  alloc_qslot,
    input  logic [1:0]         alloc_opmask,
    output logic               miss_req_valid,
    output logic [LINE_AW-1:0] miss_req_addr,
    input  logic               miss_req_ready,
    input  logic               fill_valid,
    input  logic [LINE_AW-1:0] fill_line_addr,
    output logic               wake_valid,
    output logic [1:0]         mshr_wake,
    output logic [PTCID_W-1:0] mshr_ptcid,
    output logic [QSLOTS-1:0]  mshr_qslot_out,
    output logic [OCC_W-1:0]   occupancy
);

    typedef enum logic [1:0] {StFree, StReq, StWait, StWake} state_e;

    state_e             r_state  [NUM_ENTRIES];
    logic [LINE_AW-1:0] r_addr   [NUM_ENTRIES];
    logic [PTCID_W-1:0] r_ptcid  [NUM_ENTRIES];
    logic [QSLOTS-1:0]  r_qslot  [NUM_ENTRIES];
    logic [1:0]         r_opmask [NUM_ENTRIES];

    logic               r_wake_valid;
    logic [1:0]         r_mshr_wake;
    logic [PTCID_W-1:0] r_mshr_ptcid;
    logic [QSLOTS-1:0]  r_mshr_qslot;
    logic [OCC_W-1:0]   r_occ;

    logic                   w_free_any;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_req_any;
    logic [IDX_W-1:0]       w_req_idx;
    logic                   w_wake_any;
    logic [IDX_W-1:0]       w_wake_idx;
    logic                   w_sec_hit;
    logic [NUM_ENTRIES-1:0] w_fill_hit;
    logic                   w_alloc_fire;
    logic                   w_alloc_fill;

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_req_any  = 1'b0;
        w_req_idx  = '0;
        w_wake_any = 1'b0;
        w_wake_idx = '0;
        w_sec_hit  = 1'b0;
        w_fill_hit = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (r_state[i] == StFree) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_state[i] == StReq) begin
                w_req_any = 1'b1;
                w_req_idx = IDX_W'(i);
            end
            if (r_state[i] == StWake) begin
                w_wake_any = 1'b1;
                w_wake_idx = IDX_W'(i);
            end
            if ((r_state[i] == StReq || r_state[i] == StWait) &&
                r_addr[i] == alloc_line_addr) begin
                w_sec_hit = 1'b1;
            end
            if (fill_valid && (r_state[i] == StReq || r_state[i] == StWait) &&
                r_addr[i] == fill_line_addr) begin
                w_fill_hit[i] = 1'b1;
            end
        end
    end

    assign alloc_ready    = w_free_any;
    assign w_alloc_fire   = alloc_valid && w_free_any;
    assign w_alloc_fill   = fill_valid && (fill_line_addr == alloc_line_addr);
    assign miss_req_valid = w_req_any;
    assign miss_req_addr  = w_req_any ? r_addr[w_req_idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_state[i]  <= StFree;
                r_addr[i]   <= '0;
                r_ptcid[i]  <= '0;
                r_qslot[i]  <= '0;
                r_opmask[i] <= '0;
            end
            r_wake_valid <= 1'b0;
            r_mshr_wake  <= '0;
            r_mshr_ptcid <= '0;
            r_mshr_qslot <= '0;
            r_occ        <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                unique case (r_state[i])
                    StFree: begin
                        if (w_alloc_fire && w_free_idx == IDX_W'(i)) begin
                            r_addr[i]   <= alloc_line_addr;
                            r_ptcid[i]  <= alloc_ptcid;
                            r_qslot[i]  <= alloc_qslot;
                            r_opmask[i] <= alloc_opmask;
                            if (w_alloc_fill) begin
                                r_state[i] <= StWake;
                            end else if (w_sec_hit) begin
                                r_state[i] <= StWait;
                            end else begin
                                r_state[i] <= StReq;
                            end
                        end
                    end
                    StReq: begin
                        // A fill racing the request wins; the request is simply dropped.
                        if (w_fill_hit[i]) begin
                            r_state[i] <= StWake;
                        end else if (miss_req_ready && w_req_idx == IDX_W'(i)) begin
                            r_state[i] <= StWait;
                        end
                    end
                    StWait: begin
                        if (w_fill_hit[i]) begin
                            r_state[i] <= StWake;
                        end
                    end
                    StWake: begin
                        if (w_wake_idx == IDX_W'(i)) begin
                            r_state[i] <= StFree;
                        end
                    end
                    default: r_state[i] <= StFree;
                endcase
            end
            r_wake_valid <= w_wake_any;
            r_mshr_wake  <= w_wake_any ? r_opmask[w_wake_idx] : '0;
            r_mshr_ptcid <= w_wake_any ? r_ptcid[w_wake_idx] : '0;
            r_mshr_qslot <= w_wake_any ? r_qslot[w_wake_idx] : '0;
            r_occ        <= r_occ + (w_alloc_fire ? OCC_W'(1) : OCC_W'(0))
                                  - (w_wake_any ? OCC_W'(1) : OCC_W'(0));
        end
    end

    assign wake_valid     = r_wake_valid;
    assign mshr_wake      = r_mshr_wake;
    assign mshr_ptcid     = r_mshr_ptcid;
    assign mshr_qslot_out = r_mshr_qslot;
    assign occupancy      = r_occ;

endmodule

// File: tb/tb_mshr_wake_ctrl.sv
// Self-checking bench for mshr_wake_ctrl: directed scenarios plus randomized traffic checked
// against a flag-based model of the MSHR (valid / issued / filled per entry).
module tb_mshr_wake_ctrl;
    localparam int N  = 4;
    localparam int AW = 28;
    localparam int PW = 7;
    localparam int QW = 8;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [PW-1:0] a_ptcid = '0;
    logic [QW-1:0] a_qslot = '0;
    logic [1:0]    a_op = '0;
    logic          rq_ready = 1'b0;
    logic          f_valid = 1'b0;
    logic [AW-1:0] f_addr = '0;

    logic          alloc_ready;
    logic          miss_req_valid;
    logic [AW-1:0] miss_req_addr;
    logic          wake_valid;
    logic [1:0]    mshr_wake;
    logic [PW-1:0] mshr_ptcid;
    logic [QW-1:0] mshr_qslot_out;
    logic [OW-1:0] occupancy;

    mshr_wake_ctrl #(.NUM_ENTRIES(N), .LINE_AW(AW), .PTCID_W(PW), .QSLOTS(QW)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (a_valid),
        .alloc_ready    (alloc_ready),
        .alloc_line_addr(a_addr),
        .alloc_ptcid    (a_ptcid),
        .alloc_qslot    (a_qslot),
        .alloc_opmask   (a_op),
        .miss_req_valid (miss_req_valid),
        .miss_req_addr  (miss_req_addr),
        .miss_req_ready (rq_ready),
        .fill_valid     (f_valid),
        .fill_line_addr (f_addr),
        .wake_valid     (wake_valid),
        .mshr_wake      (mshr_wake),
        .mshr_ptcid     (mshr_ptcid),
        .mshr_qslot_out (mshr_qslot_out),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: an entry is valid, may have its bus read issued (or merged), and may be filled.
    bit            m_v   [N];
    bit            m_iss [N];
    bit            m_fil [N];
    logic [AW-1:0] m_addr[N];
    logic [PW-1:0] m_pt  [N];
    logic [QW-1:0] m_qs  [N];
    logic [1:0]    m_op  [N];
    logic          e_wv;
    logic [1:0]    e_wake;
    logic [PW-1:0] e_pt;
    logic [QW-1:0] e_qs;
    logic          e_ready;
    logic          e_rv;
    logic [AW-1:0] e_raddr;
    logic [OW-1:0] e_occ;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_iss[i] = 0; m_fil[i] = 0;
            m_addr[i] = '0; m_pt[i] = '0; m_qs[i] = '0; m_op[i] = '0;
        end
        e_wv = 0; e_wake = '0; e_pt = '0; e_qs = '0;
    endtask

    task automatic model_comb();
        int cnt = 0;
        e_rv = 0;
        e_raddr = '0;
        for (int i = 0; i < N; i++) begin
            if (m_v[i]) cnt++;
            if (!e_rv && m_v[i] && !m_iss[i] && !m_fil[i]) begin
                e_rv = 1; e_raddr = m_addr[i];
            end
        end
        e_occ = OW'(cnt);
        e_ready = (cnt < N);
    endtask

    task automatic model_clock();
        int  fi = -1, ri = -1, wi = -1;
        bit  sec = 0;
        for (int i = 0; i < N; i++) begin
            if (!m_v[i] && fi < 0) fi = i;
            if (m_v[i] && !m_iss[i] && !m_fil[i] && ri < 0) ri = i;
            if (m_v[i] && m_fil[i] && wi < 0) wi = i;
            if (m_v[i] && !m_fil[i] && m_addr[i] == a_addr) sec = 1;
        end
        if (wi >= 0) begin
            e_wv = 1; e_wake = m_op[wi]; e_pt = m_pt[wi]; e_qs = m_qs[wi];
            m_v[wi] = 0; m_fil[wi] = 0; m_iss[wi] = 0;
        end else begin
            e_wv = 0; e_wake = '0; e_pt = '0; e_qs = '0;
        end
        if (ri >= 0 && rq_ready) m_iss[ri] = 1;
        if (f_valid)
            for (int i = 0; i < N; i++)
                if (m_v[i] && !m_fil[i] && m_addr[i] == f_addr) m_fil[i] = 1;
        if (a_valid && fi >= 0) begin
            m_v[fi] = 1; m_addr[fi] = a_addr; m_pt[fi] = a_ptcid;
            m_qs[fi] = a_qslot; m_op[fi] = a_op;
            m_fil[fi] = f_valid && (f_addr == a_addr);
            m_iss[fi] = m_fil[fi] || sec;
        end
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
        model_comb();
    endtask

    task automatic idle();
        a_valid = 0; f_valid = 0; rq_ready = 0;
    endtask

    task automatic set_alloc(input logic [AW-1:0] ad, input logic [PW-1:0] pt,
                             input logic [QW-1:0] qs, input logic [1:0] op);
        a_valid = 1; a_addr = ad; a_ptcid = pt; a_qslot = qs; a_op = op;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({wake_valid, mshr_wake, mshr_ptcid, mshr_qslot_out, miss_req_valid, miss_req_addr,
             occupancy} !== '0 || alloc_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_outputs: got wv=%b wk=%b pt=%h qs=%h rv=%b ra=%h occ=%0d rdy=%b want all 0, rdy=1",
                     wake_valid, mshr_wake, mshr_ptcid, mshr_qslot_out, miss_req_valid,
                     miss_req_addr, occupancy, alloc_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        model_comb();
    endtask

    task automatic test_single_miss();
        set_alloc(28'h0000010, 7'h15, 8'h04, 2'b01);
        cycle();
        idle();
        n_checks++;
        if (miss_req_valid !== 1'b1 || miss_req_addr !== 28'h0000010) begin
            n_errors++;
            $display("FAIL single_req: got v=%b a=%h want v=1 a=0000010", miss_req_valid, miss_req_addr);
        end
        rq_ready = 1;
        cycle();
        idle();
        n_checks++;
        if (miss_req_valid !== 1'b0 || occupancy !== 3'd1) begin
            n_errors++;
            $display("FAIL single_retire: got v=%b occ=%0d want v=0 occ=1", miss_req_valid, occupancy);
        end
        f_valid = 1; f_addr = 28'h0000010;
        cycle();
        idle();
        n_checks++;
        if (wake_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_wake_early: got wv=%b want 0", wake_valid);
        end
        cycle();
        n_checks++;
        if ({wake_valid, mshr_wake, mshr_ptcid, mshr_qslot_out} !== {1'b1, 2'b01, 7'h15, 8'h04}) begin
            n_errors++;
            $display("FAIL single_wake: got wv=%b wk=%b pt=%h qs=%h want 1 01 15 04",
                     wake_valid, mshr_wake, mshr_ptcid, mshr_qslot_out);
        end
        cycle();
        n_checks++;
        if (occupancy !== 3'd0 || wake_valid !== 1'b0 || mshr_ptcid !== '0) begin
            n_errors++;
            $display("FAIL single_done: got occ=%0d wv=%b pt=%h want 0 0 0", occupancy, wake_valid, mshr_ptcid);
        end
    endtask

    task automatic test_secondary_merge();
        int reqs = 0;
        for (int k = 1; k <= 3; k++) begin
            set_alloc(28'h0000020, PW'(k), QW'(1 << k), 2'b10);
            cycle();
        end
        idle();
        rq_ready = 1;
        for (int k = 0; k < 4; k++) begin
            if (miss_req_valid) reqs++;
            cycle();
        end
        idle();
        n_checks++;
        if (reqs !== 1) begin
            n_errors++;
            $display("FAIL merge_reqs: got %0d bus requests want 1", reqs);
        end
        f_valid = 1; f_addr = 28'h0000020;
        cycle();
        idle();
        cycle();
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if (wake_valid !== 1'b1 || mshr_ptcid !== PW'(k) || mshr_qslot_out !== QW'(1 << k)) begin
                n_errors++;
                $display("FAIL merge_wake%0d: got wv=%b pt=%h qs=%h want 1 %h %h",
                         k, wake_valid, mshr_ptcid, mshr_qslot_out, k, 1 << k);
            end
            cycle();
        end
        n_checks++;
        if (wake_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_errors++;
            $display("FAIL merge_drain: got wv=%b occ=%0d want 0 0", wake_valid, occupancy);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            set_alloc(28'h0000050 + AW'(k), PW'(8 + k), 8'h01, 2'b11);
            cycle();
        end
        n_checks++;
        if (alloc_ready !== 1'b0 || occupancy !== 3'd4) begin
            n_errors++;
            $display("FAIL full_state: got rdy=%b occ=%0d want 0 4", alloc_ready, occupancy);
        end
        set_alloc(28'h0000060, 7'h7f, 8'h80, 2'b01);
        cycle();
        idle();
        n_checks++;
        if (occupancy !== 3'd4 || miss_req_addr !== 28'h0000050) begin
            n_errors++;
            $display("FAIL full_ignore: got occ=%0d ra=%h want 4 0000050", occupancy, miss_req_addr);
        end
        rq_ready = 1;
        for (int k = 0; k < 4; k++) cycle();
        idle();
        f_valid = 1; f_addr = 28'h0000051;
        cycle();
        idle();
        n_checks++;
        if (alloc_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_wakestate_rdy: got %b want 0", alloc_ready);
        end
        cycle();
        n_checks++;
        if (alloc_ready !== 1'b1 || wake_valid !== 1'b1 || mshr_ptcid !== 7'h09) begin
            n_errors++;
            $display("FAIL full_freed: got rdy=%b wv=%b pt=%h want 1 1 09", alloc_ready, wake_valid, mshr_ptcid);
        end
        for (int k = 0; k < 4; k++) begin
            f_valid = (k != 1);
            f_addr = 28'h0000050 + AW'(k);
            cycle();
        end
        idle();
        for (int k = 0; k < 4; k++) cycle();
        n_checks++;
        if (occupancy !== 3'd0 || e_occ !== 3'd0) begin
            n_errors++;
            $display("FAIL full_drain: got occ=%0d want 0", occupancy);
        end
    endtask

    task automatic test_same_cycle();
        set_alloc(28'h0000030, 7'h33, 8'h10, 2'b10);
        f_valid = 1; f_addr = 28'h0000030;
        cycle();
        idle();
        n_checks++;
        if (miss_req_valid !== 1'b0 || wake_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL same_cycle_noreq: got rv=%b wv=%b want 0 0", miss_req_valid, wake_valid);
        end
        cycle();
        n_checks++;
        if (wake_valid !== 1'b1 || mshr_ptcid !== 7'h33 || mshr_wake !== 2'b10) begin
            n_errors++;
            $display("FAIL same_cycle_wake: got wv=%b pt=%h wk=%b want 1 33 10", wake_valid, mshr_ptcid, mshr_wake);
        end
        cycle();
    endtask

    task automatic test_fill_race();
        set_alloc(28'h0000040, 7'h44, 8'h20, 2'b01);
        cycle();
        idle();
        n_checks++;
        if (miss_req_valid !== 1'b1 || miss_req_addr !== 28'h0000040) begin
            n_errors++;
            $display("FAIL race_req: got v=%b a=%h want 1 0000040", miss_req_valid, miss_req_addr);
        end
        f_valid = 1; f_addr = 28'h0000040;
        cycle();
        idle();
        n_checks++;
        if (miss_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL race_drop: got rv=%b want 0", miss_req_valid);
        end
        cycle();
        n_checks++;
        if (wake_valid !== 1'b1 || mshr_ptcid !== 7'h44) begin
            n_errors++;
            $display("FAIL race_wake: got wv=%b pt=%h want 1 44", wake_valid, mshr_ptcid);
        end
        f_valid = 1; f_addr = 28'h0000077;
        cycle();
        idle();
        cycle();
        n_checks++;
        if (wake_valid !== 1'b0 || miss_req_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_errors++;
            $display("FAIL stray_fill: got wv=%b rv=%b occ=%0d want 0 0 0", wake_valid, miss_req_valid, occupancy);
        end
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        set_alloc(28'h0000080, 7'h01, 8'h01, 2'b01);
        cycle();
        set_alloc(28'h0000081, 7'h02, 8'h02, 2'b01);
        rq_ready = 1;
        cycle();
        set_alloc(28'h0000082, 7'h03, 8'h04, 2'b01);
        f_valid = 1; f_addr = 28'h0000082;
        cycle();
        idle();
        #2;
        rst = 1;
        #1;
        n_checks++;
        if ({wake_valid, mshr_wake, mshr_ptcid, mshr_qslot_out, miss_req_valid, miss_req_addr,
             occupancy} !== '0 || alloc_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_outputs: got wv=%b rv=%b occ=%0d rdy=%b want 0 0 0 1",
                     wake_valid, miss_req_valid, occupancy, alloc_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        model_comb();
        f_valid = 1; f_addr = 28'h0000080;
        for (int k = 0; k < 6; k++) begin
            cycle();
            idle();
            if (wake_valid !== 1'b0 || miss_req_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL midreset_quiet: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        logic [50:0] got, exp;
        for (int c = 0; c < 600; c++) begin
            a_valid  = ($urandom_range(1) == 1);
            a_addr   = 28'h0000100 + AW'($urandom_range(3));
            a_ptcid  = PW'($urandom);
            a_qslot  = QW'(1 << $urandom_range(QW - 1));
            a_op     = 2'($urandom_range(3));
            rq_ready = ($urandom_range(1) == 1);
            f_valid  = ($urandom_range(3) == 0);
            f_addr   = 28'h0000100 + AW'($urandom_range(4));
            cycle();
            got = {alloc_ready, miss_req_valid, miss_req_addr, wake_valid, mshr_wake, mshr_ptcid,
                   mshr_qslot_out, occupancy};
            exp = {e_ready, e_rv, e_raddr, e_wv, e_wake, e_pt, e_qs, e_occ};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random_c%0d: got %h want %h", c, got, exp);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_miss();
        test_secondary_merge();
        test_full();
        test_same_cycle();
        test_fill_race();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
